// File: rtl/iq_pkg.sv
// Shared widths and the per-slot record for the issue queue.
package iq_pkg;

    localparam int IQ_TAG_W     = 6;
    localparam int IQ_PAYLOAD_W = 32;

    typedef struct packed {
        logic                    valid;
        logic [IQ_PAYLOAD_W-1:0] payload;
        logic [IQ_TAG_W-1:0]     src1_tag;
        logic                    src1_rdy;
        logic [IQ_TAG_W-1:0]     src2_tag;
        logic                    src2_rdy;
        logic [IQ_TAG_W-1:0]     dst;
    } iq_entry_t;

endpackage

// File: rtl/issue_queue_priority_encoder.sv
// MSB-first priority encoder: reports the highest set request bit.
module priority_encoder #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx   = i[W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Reservation station: holds dispatched ops until both sources are ready,
// wakes them from CDB broadcasts and issues the highest ready slot per cycle.
module issue_queue
    import iq_pkg::*;
#(
    parameter int N_ENTRIES = 8,
    parameter int TAG_W     = IQ_TAG_W,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W,
    parameter int CNT_W     = $clog2(N_ENTRIES + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 disp_valid_i,
    output logic                 disp_ready_o,
    input  logic [PAYLOAD_W-1:0] disp_payload_i,
    input  logic [TAG_W-1:0]     disp_src1_tag_i,
    input  logic                 disp_src1_rdy_i,
    input  logic [TAG_W-1:0]     disp_src2_tag_i,
    input  logic                 disp_src2_rdy_i,
    input  logic [TAG_W-1:0]     disp_dst_tag_i,
    input  logic                 cdb_valid_i,
    input  logic [TAG_W-1:0]     cdb_tag_i,
    output logic                 iss_valid_o,
    input  logic                 iss_ready_i,
    output logic [PAYLOAD_W-1:0] iss_payload_o,
    output logic [TAG_W-1:0]     iss_dst_tag_o,
    output logic [CNT_W-1:0]     count_o
);

    localparam int IDX_W = $clog2(N_ENTRIES);

    iq_entry_t            entries [N_ENTRIES];
    logic [N_ENTRIES-1:0] free;
    logic [N_ENTRIES-1:0] eligible;
    logic [IDX_W-1:0]     alloc_idx;
    logic [IDX_W-1:0]     sel_idx;
    logic                 free_any;
    logic                 elig_any;
    logic                 do_disp;
    logic                 do_iss;
    logic [CNT_W-1:0]     count;
    iq_entry_t            new_entry;

    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            free[i]     = ~entries[i].valid;
            eligible[i] = entries[i].valid & entries[i].src1_rdy & entries[i].src2_rdy;
        end
    end

    priority_encoder #(.N(N_ENTRIES), .W(IDX_W)) u_alloc_enc (
        .req   (free),
        .idx   (alloc_idx),
        .found (free_any)
    );

    priority_encoder #(.N(N_ENTRIES), .W(IDX_W)) u_sel_enc (
        .req   (eligible),
        .idx   (sel_idx),
        .found (elig_any)
    );

    assign disp_ready_o  = free_any;
    assign iss_valid_o   = elig_any;
    assign iss_payload_o = elig_any ? entries[sel_idx].payload : '0;
    assign iss_dst_tag_o = elig_any ? entries[sel_idx].dst : '0;
    assign count_o       = count;

    // Flush squashes both handshakes, so the FU must drop anything it saw this cycle.
    assign do_disp = disp_valid_i & free_any & ~flush_i;
    assign do_iss  = elig_any & iss_ready_i & ~flush_i;

    // A tag produced in the same cycle as dispatch is captured as already ready.
    always_comb begin
        new_entry          = '0;
        new_entry.valid    = 1'b1;
        new_entry.payload  = disp_payload_i;
        new_entry.src1_tag = disp_src1_tag_i;
        new_entry.src1_rdy = disp_src1_rdy_i | (cdb_valid_i & (cdb_tag_i == disp_src1_tag_i));
        new_entry.src2_tag = disp_src2_tag_i;
        new_entry.src2_rdy = disp_src2_rdy_i | (cdb_valid_i & (cdb_tag_i == disp_src2_tag_i));
        new_entry.dst      = disp_dst_tag_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            count <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
            count <= '0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (cdb_valid_i && entries[i].valid) begin
                    if (entries[i].src1_tag == cdb_tag_i) entries[i].src1_rdy <= 1'b1;
                    if (entries[i].src2_tag == cdb_tag_i) entries[i].src2_rdy <= 1'b1;
                end
            end
            // Issue slot is valid and alloc slot is free, so they never collide.
            if (do_iss)  entries[sel_idx].valid <= 1'b0;
            if (do_disp) entries[alloc_idx]     <= new_entry;
            if (do_disp && !do_iss)      count <= count + 1'b1;
            else if (!do_disp && do_iss) count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with hand-computed expectations.
module tb_issue_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        disp_valid_i = 1'b0;
    logic        disp_ready_o;
    logic [31:0] disp_payload_i = '0;
    logic [5:0]  disp_src1_tag_i = '0;
    logic        disp_src1_rdy_i = 1'b0;
    logic [5:0]  disp_src2_tag_i = '0;
    logic        disp_src2_rdy_i = 1'b0;
    logic [5:0]  disp_dst_tag_i = '0;
    logic        cdb_valid_i = 1'b0;
    logic [5:0]  cdb_tag_i = '0;
    logic        iss_valid_o;
    logic        iss_ready_i = 1'b0;
    logic [31:0] iss_payload_o;
    logic [5:0]  iss_dst_tag_o;
    logic [3:0]  count_o;

    int n_tests = 0;
    int n_fail  = 0;

    issue_queue dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .disp_valid_i    (disp_valid_i),
        .disp_ready_o    (disp_ready_o),
        .disp_payload_i  (disp_payload_i),
        .disp_src1_tag_i (disp_src1_tag_i),
        .disp_src1_rdy_i (disp_src1_rdy_i),
        .disp_src2_tag_i (disp_src2_tag_i),
        .disp_src2_rdy_i (disp_src2_rdy_i),
        .disp_dst_tag_i  (disp_dst_tag_i),
        .cdb_valid_i     (cdb_valid_i),
        .cdb_tag_i       (cdb_tag_i),
        .iss_valid_o     (iss_valid_o),
        .iss_ready_i     (iss_ready_i),
        .iss_payload_o   (iss_payload_o),
        .iss_dst_tag_o   (iss_dst_tag_o),
        .count_o         (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_disp(input logic [31:0] pl, input logic [5:0] t1, input logic r1,
                            input logic [5:0] t2, input logic r2, input logic [5:0] dst);
        disp_valid_i    = 1'b1;
        disp_payload_i  = pl;
        disp_src1_tag_i = t1;
        disp_src1_rdy_i = r1;
        disp_src2_tag_i = t2;
        disp_src2_rdy_i = r2;
        disp_dst_tag_i  = dst;
    endtask

    task automatic disp(input logic [31:0] pl, input logic [5:0] t1, input logic r1,
                        input logic [5:0] t2, input logic r2, input logic [5:0] dst);
        set_disp(pl, t1, r1, t2, r2, dst);
        tick();
        disp_valid_i = 1'b0;
    endtask

    initial begin
        #12;
        rst_ni = 1'b1;
        tick();

        // 1: reset state, 1-cycle latency, issue
        chk("rst_disp_ready", disp_ready_o, 1);
        chk("rst_iss_valid", iss_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_payload", iss_payload_o, 0);
        chk("rst_dst", iss_dst_tag_o, 0);
        disp(32'hA5A5_0001, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5);
        chk("t1_iss_valid", iss_valid_o, 1);
        chk("t1_dst", iss_dst_tag_o, 5);
        chk("t1_payload", iss_payload_o, 32'hA5A5_0001);
        chk("t1_count", count_o, 1);
        iss_ready_i = 1'b1;
        tick();
        iss_ready_i = 1'b0;
        chk("t1_count_after", count_o, 0);
        chk("t1_iss_valid_after", iss_valid_o, 0);

        // 2: wakeup from CDB, eligible exactly one cycle later
        disp(32'h0000_0002, 6'd9, 1'b0, 6'd4, 1'b1, 6'd10);
        chk("t2_not_ready_0", iss_valid_o, 0);
        tick();
        chk("t2_not_ready_1", iss_valid_o, 0);
        cdb_valid_i = 1'b1;
        cdb_tag_i   = 6'd9;
        #1;
        chk("t2_cdb_cycle", iss_valid_o, 0);
        tick();
        cdb_valid_i = 1'b0;
        chk("t2_woken", iss_valid_o, 1);
        chk("t2_dst", iss_dst_tag_o, 10);
        iss_ready_i = 1'b1;
        tick();
        iss_ready_i = 1'b0;
        chk("t2_count", count_o, 0);

        // 3: same-cycle dispatch bypass
        cdb_valid_i = 1'b1;
        cdb_tag_i   = 6'd3;
        disp(32'h0000_0003, 6'd7, 1'b1, 6'd3, 1'b0, 6'd12);
        cdb_valid_i = 1'b0;
        chk("t3_bypass_valid", iss_valid_o, 1);
        chk("t3_bypass_dst", iss_dst_tag_o, 12);
        iss_ready_i = 1'b1;
        tick();
        iss_ready_i = 1'b0;
        chk("t3_count", count_o, 0);

        // simultaneous issue + dispatch: net count unchanged, new op takes slot 6
        disp(32'h0000_0011, 6'd1, 1'b1, 6'd1, 1'b1, 6'd17);
        iss_ready_i = 1'b1;
        disp(32'h0000_0012, 6'd1, 1'b1, 6'd1, 1'b1, 6'd18);
        iss_ready_i = 1'b0;
        chk("sim_count", count_o, 1);
        chk("sim_dst", iss_dst_tag_o, 18);
        iss_ready_i = 1'b1;
        tick();
        iss_ready_i = 1'b0;

        // 4: fill to full, 9th dispatch ignored
        for (int i = 0; i < 8; i++) begin
            disp(32'h100 + i, 6'(20 + i), 1'b0, 6'd40, 1'b0, 6'(i));
        end
        chk("t4_full_ready", disp_ready_o, 0);
        chk("t4_count", count_o, 8);
        disp(32'hDEAD, 6'd1, 1'b1, 6'd1, 1'b1, 6'd33);
        chk("t4_count_9th", count_o, 8);
        chk("t4_no_issue_9th", iss_valid_o, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t4_flush_count", count_o, 0);

        // 5: slots 7 and 6 woken together; highest issues first, stable under stall
        disp(32'h0000_0077, 6'd11, 1'b0, 6'd1, 1'b1, 6'd7);
        disp(32'h0000_0066, 6'd11, 1'b0, 6'd1, 1'b1, 6'd6);
        cdb_valid_i = 1'b1;
        cdb_tag_i   = 6'd11;
        tick();
        cdb_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("t5_stall_dst", iss_dst_tag_o, 7);
            chk("t5_stall_payload", iss_payload_o, 32'h77);
            tick();
        end
        iss_ready_i = 1'b1;
        tick();
        chk("t5_second_dst", iss_dst_tag_o, 6);
        chk("t5_second_count", count_o, 1);
        tick();
        iss_ready_i = 1'b0;
        chk("t5_empty_valid", iss_valid_o, 0);
        chk("t5_empty_count", count_o, 0);

        // 6: flush with concurrent dispatch drops everything
        for (int i = 0; i < 5; i++) begin
            disp(32'h200 + i, 6'd30, 1'b0, 6'd30, 1'b0, 6'(i));
        end
        chk("t6_count5", count_o, 5);
        flush_i = 1'b1;
        set_disp(32'hBEEF, 6'd1, 1'b1, 6'd1, 1'b1, 6'd44);
        tick();
        flush_i      = 1'b0;
        disp_valid_i = 1'b0;
        chk("t6_flush_count", count_o, 0);
        chk("t6_flush_valid", iss_valid_o, 0);
        tick();
        chk("t6_op_lost", iss_valid_o, 0);

        // async reset mid-operation
        disp(32'h0000_0055, 6'd1, 1'b1, 6'd1, 1'b1, 6'd21);
        disp(32'h0000_0056, 6'd9, 1'b0, 6'd1, 1'b1, 6'd22);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_count", count_o, 0);
        chk("arst_iss_valid", iss_valid_o, 0);
        chk("arst_dst", iss_dst_tag_o, 0);
        #4;
        rst_ni = 1'b1;
        tick();
        chk("arst_disp_ready", disp_ready_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
